// File: rtl/ram8.sv
// Eight-word synchronous register file: 3-level load demux (MSB first) and 3-level read mux (LSB first).
// Optional write-through read path enabled by defining RAM8_BYPASS_EN.
module ram8 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    output logic [WIDTH-1:0] out
);

    logic [1:0]       dmx_l1;
    logic [3:0]       dmx_l2;
    logic [7:0]       en;
    logic [WIDTH-1:0] word_q [8];
    logic [WIDTH-1:0] word_d [8];
    logic [WIDTH-1:0] mux_l1 [4];
    logic [WIDTH-1:0] mux_l2 [2];
    logic [WIDTH-1:0] rd_data;

    // Each level ANDs with its parent, so load=0 keeps every enable low even with X on address.
    assign dmx_l1[0] = load & ~address[2];
    assign dmx_l1[1] = load &  address[2];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dmx_l2
            assign dmx_l2[2*g]   = dmx_l1[g] & ~address[1];
            assign dmx_l2[2*g+1] = dmx_l1[g] &  address[1];
        end
        for (g = 0; g < 4; g++) begin : g_dmx_l3
            assign en[2*g]   = dmx_l2[g] & ~address[0];
            assign en[2*g+1] = dmx_l2[g] &  address[0];
        end
    endgenerate

    always_comb begin
        for (int unsigned k = 0; k < 8; k++) begin
            word_d[k] = word_q[k];
            if (en[k]) begin
                word_d[k] = in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < 8; k++) begin
                word_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 8; k++) begin
                word_q[k] <= word_d[k];
            end
        end
    end

    generate
        for (g = 0; g < 4; g++) begin : g_mux_l1
            assign mux_l1[g] = address[0] ? word_q[2*g+1] : word_q[2*g];
        end
        for (g = 0; g < 2; g++) begin : g_mux_l2
            assign mux_l2[g] = address[1] ? mux_l1[2*g+1] : mux_l1[2*g];
        end
    endgenerate

    assign rd_data = address[2] ? mux_l2[1] : mux_l2[0];

`ifdef RAM8_BYPASS_EN
    always_comb begin
        out = rd_data;
        if (reset) begin
            out = '0;
        end else if (load) begin
            out = in;
        end
    end
`else
    assign out = rd_data;
`endif

endmodule

// File: tb/tb_ram8.sv
// Self-checking bench for ram8: directed scenarios plus random traffic against an array model.
module tb_ram8;

    localparam int unsigned W = 16;

    logic         clk;
    logic         reset;
    logic [W-1:0] din;
    logic         load;
    logic [2:0]   addr;
    logic [W-1:0] dout;

    int unsigned  checks;
    int unsigned  errors;
    logic [W-1:0] mem [8];

    ram8 #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (din),
        .load    (load),
        .address (addr),
        .out     (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_out();
        logic [W-1:0] r;
        r = mem[addr];
`ifdef RAM8_BYPASS_EN
        if (reset) r = '0;
        else if (load) r = din;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] exp);
        #1;
        checks++;
        assert (dout === exp) else begin
            errors++;
            $error("FAIL %s addr=%0d observed=%h expected=%h", tag, addr, dout, exp);
        end
    endtask

    // Advance one edge and apply the storage rule to the model with the values seen at that edge.
    task automatic tick();
        logic         r_s;
        logic         l_s;
        logic [2:0]   a_s;
        logic [W-1:0] d_s;
        @(posedge clk);
        r_s = reset; l_s = load; a_s = addr; d_s = din;
        if (r_s === 1'b1) begin
            for (int i = 0; i < 8; i++) mem[i] = '0;
        end else if (l_s === 1'b1) begin
            mem[a_s] = d_s;
        end
        #1;
    endtask

    task automatic write(input logic [2:0] a, input logic [W-1:0] d);
        reset = 1'b0; load = 1'b1; addr = a; din = d;
        tick();
        load = 1'b0;
    endtask

    task automatic read_all(input string tag);
        load = 1'b0; reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            addr = 3'(a);
            check(tag, mem[a]);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0; load = 1'b0; addr = '0; din = '0;
        for (int i = 0; i < 8; i++) mem[i] = 'x;
        @(negedge clk);

        // Reset, then every word must read zero.
        do_reset();
        for (int a = 0; a < 8; a++) begin
            addr = 3'(a);
            check("reset_zero", 16'h0000);
        end

        // Distinct pattern to each word on consecutive edges.
        for (int k = 0; k < 8; k++) write(3'(k), 16'(16'h1111 * (k + 1)));
        for (int a = 0; a < 8; a++) begin
            addr = 3'(a);
            check("pattern", 16'(16'h1111 * (a + 1)));
        end

        // Isolated write does not leak into neighbours.
        do_reset();
        write(3'd5, 16'hBEEF);
        addr = 3'd4; check("neigh4", 16'h0000);
        addr = 3'd5; check("word5",  16'hBEEF);
        addr = 3'd6; check("neigh6", 16'h0000);

        // Reset beats a simultaneous load.
        write(3'd3, 16'h5A5A);
        reset = 1'b1; load = 1'b1; addr = 3'd3; din = 16'hFFFF;
        tick();
        reset = 1'b0; load = 1'b0;
        for (int a = 0; a < 8; a++) begin
            addr = 3'(a);
            check("reset_wins", 16'h0000);
        end

        // Read during write to the same word.
        write(3'd2, 16'h0042);
        load = 1'b1; din = 16'h1234; addr = 3'd2;
`ifdef RAM8_BYPASS_EN
        check("rdw_before", 16'h1234);
`else
        check("rdw_before", 16'h0042);
`endif
        tick();
        load = 1'b0;
        check("rdw_after", 16'h1234);

        // Back-to-back writes to one word: each visible for one cycle, last wins.
        load = 1'b1; addr = 3'd6; din = 16'hAAAA;
        tick();
        din = 16'h5555;
        check("b2b_mid", model_out());
        tick();
        load = 1'b0;
        check("b2b_last", 16'h5555);

        // load=0 with toggling data must not change contents.
        for (int c = 0; c < 8; c++) begin
            load = 1'b0; addr = 3'(c); din = (c % 2 == 0) ? 16'h0000 : 16'hFFFF;
            tick();
        end
        read_all("hold");

        // Unknown address while load=0 must not corrupt storage.
        load = 1'b0; addr = 3'bx; din = 16'hDEAD;
        tick();
        tick();
        read_all("addr_x");

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            load  = $urandom_range(0, 1) == 1;
            addr  = 3'($urandom_range(0, 7));
            din   = 16'($urandom);
            check("random", model_out());
            tick();
        end
        read_all("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
